line_memory_responder: RTL and testbench
========================================

# line_memory_responder

Main-memory side of the cache line-fill/write-back interface. Serves 512-bit line fills to the 4-way cache and absorbs dirty-line write-backs, with configurable fixed latencies. Drives the cache's `ram_ready`/`ram_in` inputs and consumes its `dirty_evicted`/`evicted_address` outputs plus victim data. Single outstanding transaction. A combined write-back + fill is always ordered write-back first.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `LINE_W`, 512, line width in bits (64 B)
- `DEPTH_LINES`, 1024, stored lines; power of two
- `READ_LATENCY`, 8, cycles from fill start to response; ≥1
- `WRITE_LATENCY`, 6, cycles from write-back start to commit; ≥1

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `fill_valid` in 1: line-fill request
- `fill_addr` in ADDR_W: fill byte address; bits [5:0] ignored
- `wb_valid` in 1: write-back request (cache `dirty_evicted`)
- `wb_addr` in ADDR_W: victim address (cache `evicted_address`); bits [5:0] ignored
- `wb_data` in LINE_W: victim line data
- `busy` out 1: transaction in progress; new requests are ignored
- `ram_ready` out 1: one-cycle fill-complete pulse, to cache `ram_ready`
- `ram_in` out LINE_W: fill data, to cache `ram_in`
- `wb_done` out 1: one-cycle write-back-committed pulse

## Operation
- Line index is `addr[6 +: log2(DEPTH_LINES)]`. Higher bits are dropped, so addresses alias modulo DEPTH_LINES.
- FSM states:
  - IDLE:
    - `wb_valid` → WB; capture `wb_addr`/`wb_data`; if `fill_valid` is also high, capture `fill_addr` and set `fill_pend`.
    - Else `fill_valid` → FILL; capture `fill_addr`.
    - Else stay in IDLE.
  - WB: count WRITE_LATENCY cycles. On the last cycle, write the line into storage and pulse `wb_done`. Then go to FILL if `fill_pend`, else to IDLE.
  - FILL: count READ_LATENCY cycles. On the last cycle, load `ram_in` from storage and pulse `ram_ready`. Then go to IDLE.
- Requests are sampled only in IDLE. Inputs are don't-care while `busy`. Nothing is queued or back-pressured; the requester must wait for `busy` to drop.
- Because the write-back commits before the fill read, a fill to the same index as the write-back returns the written data.
- `ram_in` holds its value until the next fill completes. It is not zeroed between responses.
- Storage is not cleared by reset. It is zero-initialised at time 0 for simulation only.
- Counter is sized to `$clog2(max(READ_LATENCY, WRITE_LATENCY)+1)`. It is loaded with LAT-1 on state entry and the state exits at 0. No wrap is possible.

## Timing
- Accept edge is k (IDLE, request high).
  - Fill only: `ram_ready`=1 in the cycle after edge k+READ_LATENCY; `ram_in` valid the same cycle.
  - Write-back only: `wb_done`=1 in the cycle after edge k+WRITE_LATENCY.
  - Combined: `wb_done` after edge k+WRITE_LATENCY; `ram_ready` after edge k+WRITE_LATENCY+READ_LATENCY.
- `busy` is high from the cycle after edge k through the cycle carrying the final pulse. It is low in the following cycle, when a new request may be accepted (back-to-back allowed).
- Reset values: state IDLE, `busy`=0, `ram_ready`=0, `wb_done`=0, `ram_in`=0, `fill_pend`=0.
- Reset mid-transaction:
  - Aborts immediately and emits no pulses.
  - An uncommitted write-back is discarded. An already committed write-back is kept.

## Structure
- Shared package `mem_if_pkg` holds `LINE_W`, `ADDR_W`, `OFFSET_BITS`=6, and the FSM state encoding (IDLE, WB, FILL).
- Sub-module `line_ram` holds the storage: single port, DEPTH_LINES×LINE_W, synchronous write, synchronous read. It is instantiated once.
- The top level contains the FSM, latency counter, and request capture registers.

## Test plan
- Reset, then fill 0x0000_1040 at cycle 2 → `ram_ready` in cycle 11, `ram_in`=0, `busy` high in cycles 3–11.
- Write-back 0x0000_1040 with data {16{32'hDEADBEEF}}, then fill 0x0000_1040 → `wb_done` after 6 cycles; `ram_ready` after 8 more with {16{32'hDEADBEEF}}.
- Combined `wb_valid`+`fill_valid` in one cycle, wb 0x2000 with data A, fill 0x2000 → `wb_done` at +6, `ram_ready` at +14, `ram_in`=A.
- Aliasing: write-back to 0x0001_0040 with data B, fill 0x0000_0040 → returns B (index 1 for both).
- Fill request issued while `busy` → ignored; exactly one `ram_ready` pulse observed.
- Assert `rst` during WB, 3 cycles in → no `wb_done`, outputs return to reset values next cycle, a later fill to the same line returns the old data.

Source files
------------

// File: rtl/line_memory_responder_pkg.sv
// mem_if_pkg: definitions shared by the line-memory responder and its
// interface: default bus widths, line offset width, and the FSM encoding.
package mem_if_pkg;

  localparam int ADDR_W      = 32;   // byte address width
  localparam int LINE_W      = 512;  // 64-byte cache line
  localparam int OFFSET_BITS = 6;    // byte offset within a line

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_memory_responder_if.sv
// line_memory_responder_if: request/response bundle between the cache
// (master) and the main-memory responder (slave).
//   fill_valid/fill_addr        line-fill request
//   wb_valid/wb_addr/wb_data    dirty-line write-back request
//   busy                        transaction in progress, requests ignored
//   ram_ready/ram_in            fill-complete pulse and line data
//   wb_done                     write-back-committed pulse
interface line_memory_responder_if #(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int LINE_W = mem_if_pkg::LINE_W
);

  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_data;
  logic              busy;
  logic              ram_ready;
  logic [LINE_W-1:0] ram_in;
  logic              wb_done;

  modport master (
    output fill_valid, fill_addr, wb_valid, wb_addr, wb_data,
    input  busy, ram_ready, ram_in, wb_done
  );

  modport slave (
    input  fill_valid, fill_addr, wb_valid, wb_addr, wb_data,
    output busy, ram_ready, ram_in, wb_done
  );

endinterface

// File: rtl/line_memory_responder_line_ram.sv
// line_ram: single-port DEPTH x WIDTH line storage with synchronous write
// and registered read.
//   clk, rst   clock; rst clears only the read register, never the array
//   we         write wr_data to addr at the clock edge
//   re         load rd_data from addr at the clock edge; rd_data holds
//              otherwise
//   addr       line index shared by read and write
module line_ram import mem_if_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = mem_if_pkg::LINE_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  // Declaration initialiser gives a zeroed array at time 0; reset does not
  // touch the contents.
  logic [WIDTH-1:0] mem_reg [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wr_data;
    end
  end

  // Read register kept in its own process so the array stays free of reset
  // logic and still maps onto block RAM with an output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem_reg[addr];
    end
  end

endmodule

// File: rtl/line_memory_responder.sv
// line_memory_responder: main-memory side of the cache line-fill/write-back
// path. One transaction at a time; a combined request runs the write-back
// first so a fill of the same line sees the new data.
//   clk, rst   single clock, synchronous active-high reset
//   bus        slave side of line_memory_responder_if (requests in,
//              busy/ram_ready/ram_in/wb_done out)
module line_memory_responder import mem_if_pkg::*; #(
  parameter int ADDR_W        = mem_if_pkg::ADDR_W,
  parameter int LINE_W        = mem_if_pkg::LINE_W,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 6
) (
  input  logic clk,
  input  logic rst,
  line_memory_responder_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = max_int(READ_LATENCY, WRITE_LATENCY);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              fill_pend_reg, fill_pend_next;
  logic [IDX_W-1:0]  fill_idx_reg, fill_idx_next;
  logic [IDX_W-1:0]  wb_idx_reg, wb_idx_next;
  logic [LINE_W-1:0] wb_data_reg, wb_data_next;
  logic              ram_ready_reg, ram_ready_next;
  logic              wb_done_reg, wb_done_next;

  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [LINE_W-1:0] ram_rd_data;

  // Only the index bits are used; offset and aliasing high bits are dropped.
  logic [ADDR_W-1:0] fill_addr_w, wb_addr_w;
  logic [IDX_W-1:0]  fill_idx_in, wb_idx_in;
  logic              unused_addr_bits;

  assign fill_addr_w      = bus.fill_addr;
  assign wb_addr_w        = bus.wb_addr;
  assign fill_idx_in      = fill_addr_w[OFFSET_BITS +: IDX_W];
  assign wb_idx_in        = wb_addr_w[OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{fill_addr_w, wb_addr_w};

  // The completion pulse is registered, so it lands in the cycle after the
  // FSM has already returned to IDLE; that cycle still counts as busy and
  // must not accept a request.
  logic pulse_cycle;
  assign pulse_cycle = ram_ready_reg | wb_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      fill_pend_reg <= 1'b0;
      fill_idx_reg  <= '0;
      wb_idx_reg    <= '0;
      wb_data_reg   <= '0;
      ram_ready_reg <= 1'b0;
      wb_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      fill_pend_reg <= fill_pend_next;
      fill_idx_reg  <= fill_idx_next;
      wb_idx_reg    <= wb_idx_next;
      wb_data_reg   <= wb_data_next;
      ram_ready_reg <= ram_ready_next;
      wb_done_reg   <= wb_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    fill_pend_next = fill_pend_reg;
    fill_idx_next  = fill_idx_reg;
    wb_idx_next    = wb_idx_reg;
    wb_data_next   = wb_data_reg;
    ram_ready_next = 1'b0;
    wb_done_next   = 1'b0;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_addr       = fill_idx_reg;

    case (state_reg)
      ST_IDLE: begin
        if (!pulse_cycle) begin
          if (bus.wb_valid) begin
            state_next     = ST_WB;
            cnt_next       = WR_LOAD;
            wb_idx_next    = wb_idx_in;
            wb_data_next   = bus.wb_data;
            fill_pend_next = bus.fill_valid;
            if (bus.fill_valid) begin
              fill_idx_next = fill_idx_in;
            end
          end else if (bus.fill_valid) begin
            state_next     = ST_FILL;
            cnt_next       = RD_LOAD;
            fill_idx_next  = fill_idx_in;
            fill_pend_next = 1'b0;
          end
        end
      end

      ST_WB: begin
        ram_addr = wb_idx_reg;
        if (cnt_reg == '0) begin
          ram_we       = 1'b1;
          wb_done_next = 1'b1;
          if (fill_pend_reg) begin
            state_next     = ST_FILL;
            cnt_next       = RD_LOAD;
            fill_pend_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      ST_FILL: begin
        if (cnt_reg == '0) begin
          ram_re         = 1'b1;
          ram_ready_next = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A reset landing on the commit cycle must discard the write-back.
  line_ram #(
    .DEPTH (DEPTH_LINES),
    .WIDTH (LINE_W)
  ) u_line_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we & ~rst),
    .re      (ram_re & ~rst),
    .addr    (ram_addr),
    .wr_data (wb_data_reg),
    .rd_data (ram_rd_data)
  );

  assign bus.ram_in    = ram_rd_data;
  assign bus.ram_ready = ram_ready_reg;
  assign bus.wb_done   = wb_done_reg;
  assign bus.busy      = (state_reg != ST_IDLE) | pulse_cycle;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: a table of single transactions
// (cycle of each pulse relative to the accept edge, pulse count, busy window,
// returned line) followed by hand-written sequences for requests while busy
// and reset in the middle of a write-back.
module tb_line_memory_responder;

  localparam int RL = 8;
  localparam int WL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  line_memory_responder_if #(.ADDR_W(32), .LINE_W(512)) bus ();

  line_memory_responder #(
    .ADDR_W        (32),
    .LINE_W        (512),
    .DEPTH_LINES   (1024),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    bit           do_wb;
    bit           do_fill;
    logic [31:0]  wa;
    logic [511:0] wd;
    logic [31:0]  fa;
    int           exp_wb;    // sample index of wb_done, 0 = none
    int           exp_rd;    // sample index of ram_ready, 0 = none
    logic [511:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge and samples 1 ns after every following
  // rising edge; sample c=1 is the cycle after the accept edge. With hold set
  // the request lines stay high (plus a junk write-back) until the final
  // pulse, and the monitor runs on to catch any extra pulse.
  task automatic run_txn(input bit do_wb, input bit do_fill, input logic [31:0] wa,
                         input logic [511:0] wd, input logic [31:0] fa, input bit hold,
                         output int wb_cyc, output int rd_cyc, output int pulses,
                         output bit busy_ok, output logic [511:0] data);
    int fin;
    bit done;
    wb_cyc = 0; rd_cyc = 0; pulses = 0; busy_ok = 1'b1; data = '0; fin = 0; done = 1'b0;
    @(negedge clk);
    bus.wb_valid   = do_wb;
    bus.fill_valid = do_fill;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.fill_addr  = fa;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        if (hold) begin
          bus.wb_valid = 1'b1;
        end else begin
          bus.wb_valid   = 1'b0;
          bus.fill_valid = 1'b0;
        end
      end
      if (bus.wb_done === 1'b1) begin
        pulses++;
        if (wb_cyc == 0) wb_cyc = c;
      end
      if (bus.ram_ready === 1'b1) begin
        pulses++;
        if (rd_cyc == 0) begin
          rd_cyc = c;
          data   = bus.ram_in;
        end
      end
      if (fin == 0 && ((do_fill && bus.ram_ready === 1'b1) || (!do_fill && bus.wb_done === 1'b1))) begin
        fin = c;
        bus.wb_valid   = 1'b0;
        bus.fill_valid = 1'b0;
      end
      if (fin == 0 || c == fin) begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end else if (c == fin + 1) begin
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        if (!hold) done = 1'b1;
      end else if (c >= fin + 12) begin
        done = 1'b1;
      end
    end
    bus.wb_valid   = 1'b0;
    bus.fill_valid = 1'b0;
  endtask

  task automatic check_txn(input string name, input bit do_wb, input bit do_fill,
                           input logic [31:0] wa, input logic [511:0] wd, input logic [31:0] fa,
                           input bit hold, input int exp_wb, input int exp_rd,
                           input int exp_pulses, input logic [511:0] exp_data);
    int wb_cyc, rd_cyc, pulses;
    bit busy_ok;
    logic [511:0] data;
    run_txn(do_wb, do_fill, wa, wd, fa, hold, wb_cyc, rd_cyc, pulses, busy_ok, data);
    chk({name, ".wb_done_cycle"},   512'(wb_cyc), 512'(exp_wb));
    chk({name, ".ram_ready_cycle"}, 512'(rd_cyc), 512'(exp_rd));
    chk({name, ".pulse_count"},     512'(pulses), 512'(exp_pulses));
    chk({name, ".busy_window"},     512'(busy_ok), 512'(1));
    chk({name, ".ram_in"},          data, exp_data);
    $display("txn %s: wb_cyc=%0d rd_cyc=%0d pulses=%0d busy_ok=%0d", name, wb_cyc, rd_cyc, pulses, busy_ok);
  endtask

  initial begin
    logic [511:0] zero, d1, da, db, dc, junk;
    int wb_seen;

    zero = '0;
    d1   = {16{32'hDEADBEEF}};
    da   = {16{32'hA5A50001}};
    db   = {16{32'h0B0B0B0B}};
    dc   = {16{32'hC0C01234}};
    junk = {16{32'hEEEEEEEE}};

    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;

    // Storage starts zeroed; the table order relies on earlier write-backs.
    vecs[0] = '{"fill_cold",   1'b0, 1'b1, 32'h0,         zero, 32'h0000_1040, 0,      RL + 1,      zero};
    vecs[1] = '{"wb_1040",     1'b1, 1'b0, 32'h0000_1040, d1,   32'h0,         WL + 1, 0,           zero};
    vecs[2] = '{"fill_1040",   1'b0, 1'b1, 32'h0,         zero, 32'h0000_1040, 0,      RL + 1,      d1};
    vecs[3] = '{"comb_2000",   1'b1, 1'b1, 32'h0000_2000, da,   32'h0000_2000, WL + 1, WL + RL + 1, da};
    vecs[4] = '{"wb_alias",    1'b1, 1'b0, 32'h0001_0040, db,   32'h0,         WL + 1, 0,           zero};
    vecs[5] = '{"fill_alias",  1'b0, 1'b1, 32'h0,         zero, 32'h0000_0040, 0,      RL + 1,      db};
    vecs[6] = '{"fill_unwr",   1'b0, 1'b1, 32'h0,         zero, 32'h0000_2040, 0,      RL + 1,      zero};
    vecs[7] = '{"comb_split",  1'b1, 1'b1, 32'h0000_3000, dc,   32'h0000_1040, WL + 1, WL + RL + 1, d1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",      512'(bus.busy),      512'(0));
    chk("reset.ram_ready", 512'(bus.ram_ready), 512'(0));
    chk("reset.wb_done",   512'(bus.wb_done),   512'(0));
    chk("reset.ram_in",    bus.ram_in,          zero);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      check_txn(vecs[i].name, vecs[i].do_wb, vecs[i].do_fill, vecs[i].wa, vecs[i].wd,
                vecs[i].fa, 1'b0, vecs[i].exp_wb, vecs[i].exp_rd,
                int'(vecs[i].do_wb) + int'(vecs[i].do_fill), vecs[i].exp_data);
    end

    // Requests held high while busy must be ignored: one fill, no write-back.
    check_txn("busy_ignore", 1'b0, 1'b1, 32'h0000_1040, junk, 32'h0000_1040, 1'b1,
              0, RL + 1, 1, d1);

    // Reset three cycles into a write-back: no commit, outputs back to reset.
    @(negedge clk);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 32'h0000_1040;
    bus.wb_data  = junk;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid.busy",      512'(bus.busy),      512'(0));
    chk("rst_mid.ram_ready", 512'(bus.ram_ready), 512'(0));
    chk("rst_mid.wb_done",   512'(bus.wb_done),   512'(0));
    chk("rst_mid.ram_in",    bus.ram_in,          zero);
    $display("txn rst_mid: busy=%0d ram_ready=%0d wb_done=%0d", bus.busy, bus.ram_ready, bus.wb_done);
    @(negedge clk);
    rst = 1'b0;
    wb_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.wb_done === 1'b1 || bus.busy === 1'b1) wb_seen++;
    end
    chk("rst_mid.no_activity", 512'(wb_seen), 512'(0));
    check_txn("rst_mid_fill", 1'b0, 1'b1, 32'h0, zero, 32'h0000_1040, 1'b0, 0, RL + 1, 1, d1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
